// File: rtl/unidade_controle_pkg.sv
// Shared types and constants for the multicycle control unit: state encoding,
// ULA op codes, bus mux select codes and instruction field positions.
package pacote_controle;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned NREGS  = 8;

    typedef enum logic [1:0] {
        StIdle,
        StT1,
        StT2,
        StT3
    } state_e;

    localparam logic [2:0] ULA_ADD  = 3'd0;
    localparam logic [2:0] ULA_SUB  = 3'd1;
    localparam logic [2:0] ULA_AND  = 3'd2;
    localparam logic [2:0] ULA_SLL  = 3'd3;
    localparam logic [2:0] ULA_SRL  = 3'd4;
    localparam logic [2:0] ULA_SLT  = 3'd5;
    localparam logic [2:0] ULA_MVNZ = 3'd6;
    localparam logic [2:0] ULA_MV   = 3'd7;

    // Bus select codes 0..7 address R0..R7 directly.
    localparam logic [3:0] BUS_G    = 4'd8;
    localparam logic [3:0] BUS_DIN  = 4'd9;
    localparam logic [3:0] BUS_NONE = 4'd15;

    localparam int unsigned OP_HI   = 15;
    localparam int unsigned OP_LO   = 13;
    localparam int unsigned RX_HI   = 12;
    localparam int unsigned RX_LO   = 10;
    localparam int unsigned RY_HI   = 9;
    localparam int unsigned RY_LO   = 7;
    localparam int unsigned IMM_BIT = 6;

endpackage

// File: rtl/unidade_controle_if.sv
// Control-unit bundle: instruction input side (run/din) and datapath strobes.
// master = control unit, slave = instruction source + datapath.
interface unidade_controle_if;
    import pacote_controle::*;

    logic              run;
    logic [DATA_W-1:0] din;
    logic [2:0]        ula_ctrl;
    logic [3:0]        bus_sel;
    logic [NREGS-1:0]  r_in;
    logic              a_in;
    logic              g_in;
    logic              req_imm;
    logic              busy;
    logic              done;

    modport master (
        input  run, din,
        output ula_ctrl, bus_sel, r_in, a_in, g_in, req_imm, busy, done
    );

    modport slave (
        output run, din,
        input  ula_ctrl, bus_sel, r_in, a_in, g_in, req_imm, busy, done
    );

endinterface

// File: rtl/unidade_controle_dec3to8.sv
// 3-bit index to 8-bit one-hot decoder with enable; drives register write enables.
module dec3to8 (
    input  logic [2:0] idx_i,
    input  logic       en_i,
    output logic [7:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[idx_i] = 1'b1;
        end
    end

endmodule

// File: rtl/unidade_controle.sv
// Multicycle control FSM for the 8-op ULA datapath (IDLE -> T1 -> T2 -> T3).
// Optional FAST_MV_EN: register-to-register MV finishes in T1.
module unidade_controle
    import pacote_controle::*;
(
    input  logic               clock,
    input  logic               reset,
    unidade_controle_if.master ctl
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] ir_q, ir_d;

    logic [2:0] op, rx, ry;
    logic       imm;
    logic       fast_mv;
    logic       rin_en;
    logic [7:0] r_in;
    logic       unused_ir;

    assign op        = ir_q[OP_HI:OP_LO];
    assign rx        = ir_q[RX_HI:RX_LO];
    assign ry        = ir_q[RY_HI:RY_LO];
    assign imm       = ir_q[IMM_BIT];
    assign unused_ir = ^ir_q[IMM_BIT-1:0];

`ifdef FAST_MV_EN
    assign fast_mv = (op == ULA_MV) && !imm;
`else
    assign fast_mv = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        unique case (state_q)
            StIdle: begin
                if (ctl.run) begin
                    ir_d    = ctl.din;
                    state_d = StT1;
                end
            end
            StT1:    state_d = fast_mv ? StIdle : StT2;
            StT2:    state_d = StT3;
            StT3:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ctl.ula_ctrl = ULA_ADD;
        ctl.bus_sel  = BUS_NONE;
        ctl.a_in     = 1'b0;
        ctl.g_in     = 1'b0;
        ctl.req_imm  = 1'b0;
        ctl.busy     = 1'b0;
        ctl.done     = 1'b0;
        rin_en       = 1'b0;
        unique case (state_q)
            StIdle: ;
            StT1: begin
                ctl.busy = 1'b1;
                if (fast_mv) begin
                    // Copy rY straight into rX, bypassing A and G.
                    ctl.bus_sel = {1'b0, ry};
                    rin_en      = 1'b1;
                    ctl.done    = 1'b1;
                end else begin
                    ctl.bus_sel = {1'b0, rx};
                    ctl.a_in    = 1'b1;
                end
            end
            StT2: begin
                ctl.busy     = 1'b1;
                ctl.bus_sel  = imm ? BUS_DIN : {1'b0, ry};
                ctl.req_imm  = imm;
                ctl.ula_ctrl = op;
                ctl.g_in     = 1'b1;
            end
            StT3: begin
                ctl.busy    = 1'b1;
                ctl.bus_sel = BUS_G;
                rin_en      = 1'b1;
                ctl.done    = 1'b1;
            end
            default: ;
        endcase
    end

    dec3to8 u_dec (
        .idx_i    (rx),
        .en_i     (rin_en),
        .onehot_o (r_in)
    );

    assign ctl.r_in = r_in;

endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench for unidade_controle: per-cycle expected strobe vectors are queued as
// stimulus is driven and popped one per clock. Honours FAST_MV_EN when defined.
module tb_unidade_controle;
    import pacote_controle::*;

    typedef struct packed {
        logic [2:0] ula;
        logic [3:0] bus;
        logic [7:0] rin;
        logic       a;
        logic       g;
        logic       imm;
        logic       busy;
        logic       done;
    } vec_t;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    unidade_controle_if bus_if ();

    unidade_controle u_dut (
        .clock (clock),
        .reset (reset),
        .ctl   (bus_if)
    );

    vec_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic vec_t v_idle();
        vec_t v;
        v     = '0;
        v.bus = 4'd15;
        return v;
    endfunction

    function automatic logic [7:0] onehot(input logic [2:0] i);
        logic [7:0] r;
        r = 8'h01 << i;
        return r;
    endfunction

    function automatic bit is_fast(input logic [15:0] w);
`ifdef FAST_MV_EN
        return (w[15:13] == 3'd7) && !w[6];
`else
        return (w[15:13] == 3'd7) && 1'b0;
`endif
    endfunction

    task automatic push_t1(input logic [15:0] w);
        vec_t v = v_idle();
        v.bus  = {1'b0, w[12:10]};
        v.a    = 1'b1;
        v.busy = 1'b1;
        exp_q.push_back(v);
    endtask

    task automatic push_t2(input logic [15:0] w);
        vec_t v = v_idle();
        v.bus  = w[6] ? 4'd9 : {1'b0, w[9:7]};
        v.imm  = w[6];
        v.ula  = w[15:13];
        v.g    = 1'b1;
        v.busy = 1'b1;
        exp_q.push_back(v);
    endtask

    task automatic push_t3(input logic [15:0] w);
        vec_t v = v_idle();
        v.bus  = 4'd8;
        v.rin  = onehot(w[12:10]);
        v.busy = 1'b1;
        v.done = 1'b1;
        exp_q.push_back(v);
    endtask

    task automatic push_instr(input logic [15:0] w, output int n);
        vec_t v = v_idle();
        if (is_fast(w)) begin
            v.bus  = {1'b0, w[9:7]};
            v.rin  = onehot(w[12:10]);
            v.busy = 1'b1;
            v.done = 1'b1;
            exp_q.push_back(v);
            n = 1;
        end else begin
            push_t1(w);
            push_t2(w);
            push_t3(w);
            n = 3;
        end
    endtask

    task automatic check(input string tag);
        vec_t obs;
        vec_t exp;
        obs.ula  = bus_if.ula_ctrl;
        obs.bus  = bus_if.bus_sel;
        obs.rin  = bus_if.r_in;
        obs.a    = bus_if.a_in;
        obs.g    = bus_if.g_in;
        obs.imm  = bus_if.req_imm;
        obs.busy = bus_if.busy;
        obs.done = bus_if.done;
        n_chk++;
        if (exp_q.size() == 0) begin
            $error("FAIL %s scoreboard empty, observed=%h", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) n_pass++;
            else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clock);
        #1;
        check(tag);
    endtask

    // Issue one instruction from IDLE, run for its full length, then check the idle cycle.
    task automatic do_instr(input logic [15:0] w, input string tag);
        int n;
        bus_if.din = w;
        bus_if.run = 1'b1;
        push_instr(w, n);
        tick(tag);
        bus_if.run = 1'b0;
        for (int i = 1; i < n; i++) tick(tag);
        exp_q.push_back(v_idle());
        tick({tag, "_idle"});
    endtask

    initial begin
        int n;
        reset      = 1'b1;
        bus_if.run = 1'b0;
        bus_if.din = '0;

        exp_q.push_back(v_idle());
        tick("reset0");
        exp_q.push_back(v_idle());
        tick("reset1");
        reset = 1'b0;
        exp_q.push_back(v_idle());
        tick("idle_norun");

        do_instr(16'h2A80, "sub_r2_r5");
        do_instr(16'hE440, "mvi_r1");
        do_instr(16'hE980, "mv_r2_r3");

        // Reset asserted mid-instruction, with run high during the second reset cycle.
        bus_if.din = 16'h0E00;
        bus_if.run = 1'b1;
        push_t1(16'h0E00);
        tick("rst_mid_t1");
        bus_if.run = 1'b0;
        push_t2(16'h0E00);
        tick("rst_mid_t2");
        reset = 1'b1;
        exp_q.push_back(v_idle());
        tick("rst_mid_r0");
        bus_if.din = 16'h2A80;
        bus_if.run = 1'b1;
        exp_q.push_back(v_idle());
        tick("rst_mid_r1");
        reset = 1'b0;
        do_instr(16'h2A80, "after_rst");

        // run and din changed while busy must not disturb the instruction in flight.
        bus_if.din = 16'h0E00;
        bus_if.run = 1'b1;
        push_instr(16'h0E00, n);
        tick("ign_t1");
        bus_if.din = 16'hFFFF;
        tick("ign_t2");
        bus_if.run = 1'b0;
        tick("ign_t3");
        exp_q.push_back(v_idle());
        tick("ign_idle");
        exp_q.push_back(v_idle());
        tick("ign_idle2");

        // run held high: ADD then SLT with one IDLE cycle between, done every 4th cycle.
        bus_if.din = 16'h0E00;
        bus_if.run = 1'b1;
        push_instr(16'h0E00, n);
        tick("b2b_add_t1");
        bus_if.din = 16'hBB80;
        tick("b2b_add_t2");
        tick("b2b_add_t3");
        exp_q.push_back(v_idle());
        tick("b2b_idle");
        push_instr(16'hBB80, n);
        tick("b2b_slt_t1");
        tick("b2b_slt_t2");
        bus_if.run = 1'b0;
        tick("b2b_slt_t3");
        exp_q.push_back(v_idle());
        tick("b2b_end");

        n_chk++;
        assert (exp_q.size() == 0) n_pass++;
        else $error("FAIL drain observed=%0d expected=0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
